// File: rtl/mux_stream_if.sv
// Stream bus between the producer channels, mux_stream_rr and the consumer.
// master = the multiplexer side, slave = the producers/consumer side.
//
// Handshake: a word moves on a rising clk edge exactly when valid and ready
// are both 1 on that edge. A producer raises in_valid[i] with in_data[i] and
// holds both stable until it sees in_ready[i]; ready may depend on valid in
// the same cycle, valid never depends on ready. The output side follows the
// same rule with out_valid/out_ready.
interface mux_stream_if #(
   parameter int NCH = 4,
   parameter int DW  = 8
) ();
   localparam int SELW = $clog2(NCH);

   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [DW-1:0]     out_data;
   logic [SELW-1:0]   out_ch;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/mux_stream_rr.sv
// mux_stream_rr: NCH-channel, DW-bit streaming multiplexer with a single-entry
// registered output, fixed-select (mode=1) or round-robin (mode=0) arbitration,
// and a source-channel tag on every output word.
// Optional feature: define MUX_STREAM_CNT_EN to add the 16-bit xfer_cnt port
// counting completed output transfers (wraps at 65535 -> 0).
module mux_stream_rr #(
   parameter  int NCH  = 4,
   parameter  int DW   = 8,
   localparam int SELW = $clog2(NCH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
`ifdef MUX_STREAM_CNT_EN
   output logic [15:0]     xfer_cnt,
`endif
   mux_stream_if.master    bus
);

   logic [SELW-1:0] r_ptr;
   logic [DW-1:0]   r_out_data;
   logic [SELW-1:0] r_out_ch;
   logic            r_out_valid;

   logic            w_load_en;
   logic            w_fix_gv;
   logic [SELW-1:0] w_fix_g;
   logic            w_rr_gv;
   logic [SELW-1:0] w_rr_g;
   logic            w_grant_valid;
   logic [SELW-1:0] w_grant;
   logic            w_take;
   logic [DW-1:0]   w_grant_data;
   logic [NCH-1:0]  w_in_ready;

   // The output register can accept a word when empty or draining this cycle.
   assign w_load_en = !r_out_valid || bus.out_ready;

   // Fixed select: only sel may win; a sel value >= NCH matches no channel.
   always_comb begin
      w_fix_gv = 1'b0;
      w_fix_g  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SELW'(k) && bus.in_valid[k]) begin
            w_fix_gv = 1'b1;
            w_fix_g  = SELW'(k);
         end
      end
   end

   // Round robin: first valid channel above ptr, else first valid at or below ptr.
   always_comb begin
      w_rr_gv = 1'b0;
      w_rr_g  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!w_rr_gv && SELW'(k) > r_ptr && bus.in_valid[k]) begin
            w_rr_gv = 1'b1;
            w_rr_g  = SELW'(k);
         end
      end
      for (int k = 0; k < NCH; k++) begin
         if (!w_rr_gv && SELW'(k) <= r_ptr && bus.in_valid[k]) begin
            w_rr_gv = 1'b1;
            w_rr_g  = SELW'(k);
         end
      end
   end

   assign w_grant_valid = mode ? w_fix_gv : w_rr_gv;
   assign w_grant       = mode ? w_fix_g  : w_rr_g;
   assign w_take        = w_load_en && w_grant_valid;

   // Select the granted channel's data word.
   always_comb begin
      w_grant_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (w_grant == SELW'(k)) w_grant_data = bus.in_data[k*DW +: DW];
      end
   end

   // One-hot ready to the granted channel; held at zero while in reset.
   always_comb begin
      w_in_ready = '0;
      if (rst_n && w_take) begin
         for (int k = 0; k < NCH; k++) begin
            if (w_grant == SELW'(k)) w_in_ready[k] = 1'b1;
         end
      end
   end

   // Output register and arbitration pointer; a load replaces a draining word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= SELW'(NCH - 1);
      end else if (w_take) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_grant_data;
         r_out_ch    <= w_grant;
         r_ptr       <= w_grant;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_valid = r_out_valid;

`ifdef MUX_STREAM_CNT_EN
   logic [15:0] r_xfer_cnt;

   // Count completed output transfers, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           r_xfer_cnt <= '0;
      else if (r_out_valid && bus.out_ready) r_xfer_cnt <= r_xfer_cnt + 16'd1;
   end

   assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr (NCH=4, DW=8): table of single-arbitration vectors
// from reset, hand-written multi-cycle sequences, random traffic, and a
// negedge scoreboard with an expected-word queue.
module tb_mux_stream_rr;
   localparam int NCH  = 4;
   localparam int DW   = 8;
   localparam int SELW = $clog2(NCH);

   logic            clk;
   logic            rst_n;
   logic            mode;
   logic [SELW-1:0] sel;
`ifdef MUX_STREAM_CNT_EN
   logic [15:0]     xfer_cnt;
`endif

   mux_stream_if #(.NCH(NCH), .DW(DW)) bus ();

   mux_stream_rr #(.NCH(NCH), .DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .sel      (sel),
`ifdef MUX_STREAM_CNT_EN
      .xfer_cnt (xfer_cnt),
`endif
      .bus      (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
      mode          = 1'b0;
      sel           = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- scoreboard / reference model ----------------
   logic [SELW+DW-1:0] exp_q[$];
   bit                 m_ov;
   int                 m_ptr;

   function automatic void model_grant(input logic md, input logic [SELW-1:0] s,
                                       input logic [NCH-1:0] v, input int p,
                                       output bit gv, output int g);
      gv = 1'b0;
      g  = 0;
      if (md) begin
         if (int'(s) < NCH && v[s]) begin
            gv = 1'b1;
            g  = int'(s);
         end
      end else begin
         for (int k = 1; k <= NCH; k++) begin
            if (!gv && v[(p + k) % NCH]) begin
               gv = 1'b1;
               g  = (p + k) % NCH;
            end
         end
      end
   endfunction

   initial begin
      m_ov  = 1'b0;
      m_ptr = NCH - 1;
      forever begin
         bit                 load_en;
         bit                 gv;
         int                 g;
         logic [NCH-1:0]     exp_rdy;
         logic [SELW+DW-1:0] head;
         logic [DW-1:0]      gdata;
         @(negedge clk);
         if (!rst_n) begin
            m_ov  = 1'b0;
            m_ptr = NCH - 1;
            exp_q.delete();
         end else begin
            load_en = !m_ov || bus.out_ready;
            model_grant(mode, sel, bus.in_valid, m_ptr, gv, g);
            exp_rdy = (load_en && gv) ? (NCH'(1) << g) : '0;
            check("sb_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("sb_out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_queue: output valid but no expected word");
               end else begin
                  head = exp_q[0];
                  check("sb_out_ch", 32'(bus.out_ch), 32'(head[SELW+DW-1:DW]));
                  check("sb_out_data", 32'(bus.out_data), 32'(head[DW-1:0]));
                  if (bus.out_ready) void'(exp_q.pop_front());
               end
            end
            if (load_en && gv) begin
               gdata = bus.in_data[g*DW +: DW];
               exp_q.push_back({SELW'(g), gdata});
               m_ptr = g;
               m_ov  = 1'b1;
            end else if (m_ov && bus.out_ready) begin
               m_ov = 1'b0;
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic            md;
      logic [SELW-1:0] s;
      logic [NCH-1:0]  v;
      logic [NCH-1:0]  rdy;
      logic            ov;
      logic [SELW-1:0] ch;
      logic [DW-1:0]   d;
   } vec_t;

   vec_t vecs[8];

   // ---------------- main sequence ----------------
   initial begin
      bus.in_data = 32'h3CA5_5A11;   // ch3=3C ch2=A5 ch1=5A ch0=11

      // Each vector starts from reset: empty output, ptr=3 so ch0 is first in RR.
      vecs[0] = '{1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1, 2'd2, 8'hA5};
      vecs[1] = '{1'b1, 2'd3, 4'b0111, 4'b0000, 1'b0, 2'd0, 8'h00};
      vecs[2] = '{1'b0, 2'd0, 4'b0111, 4'b0001, 1'b1, 2'd0, 8'h11};
      vecs[3] = '{1'b0, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1, 8'h5A};
      vecs[4] = '{1'b0, 2'd0, 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h3C};
      vecs[5] = '{1'b1, 2'd0, 4'b1110, 4'b0000, 1'b0, 2'd0, 8'h00};
      vecs[6] = '{1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
      vecs[7] = '{1'b1, 2'd1, 4'b1111, 4'b0010, 1'b1, 2'd1, 8'h5A};

      do_reset();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_ch", 32'(bus.out_ch), 32'd0);
`ifdef MUX_STREAM_CNT_EN
      check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif

      for (int i = 0; i < 8; i++) begin
         do_reset();
         mode          = vecs[i].md;
         sel           = vecs[i].s;
         bus.in_valid  = vecs[i].v;
         bus.out_ready = 1'b1;
         #1;
         check("vec_in_ready", 32'(bus.in_ready), 32'(vecs[i].rdy));
         tick();
         check("vec_out_valid", 32'(bus.out_valid), 32'(vecs[i].ov));
         check("vec_out_ch", 32'(bus.out_ch), 32'(vecs[i].ch));
         check("vec_out_data", 32'(bus.out_data), 32'(vecs[i].d));
      end

      // Round robin, all valid, full throughput: 0,1,2,3,0,1,2,3.
      do_reset();
      mode = 1'b0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rr_out_valid", 32'(bus.out_valid), 32'd1);
         check("rr_out_ch", 32'(bus.out_ch), 32'(k % NCH));
      end

      // Stall with in_valid=1010: ch1 held, no ready; then ch3, then ch1.
      do_reset();
      mode = 1'b0; bus.in_valid = 4'b1010; bus.out_ready = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         check("stall_out_ch", 32'(bus.out_ch), 32'd1);
         check("stall_out_data", 32'(bus.out_data), 32'h5A);
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("release_ch3", 32'(bus.out_ch), 32'd3);
      tick();
      check("release_ch1", 32'(bus.out_ch), 32'd1);

      // Fixed sel=3 with ch3 idle: nothing granted; switching to RR grants ch0.
      do_reset();
      mode = 1'b1; sel = 2'd3; bus.in_valid = 4'b0111; bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("fix_idle_in_ready", 32'(bus.in_ready), 32'd0);
         check("fix_idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
      mode = 1'b0;
      #1;
      check("switch_in_ready", 32'(bus.in_ready), 32'b0001);
      tick();
      check("switch_out_ch", 32'(bus.out_ch), 32'd0);
      check("switch_out_valid", 32'(bus.out_valid), 32'd1);

      // Reset mid-stream clears the output without waiting for a clock.
      do_reset();
      mode = 1'b0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_out_data", 32'(bus.out_data), 32'd0);
      check("async_rst_out_ch", 32'(bus.out_ch), 32'd0);
      check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("in_rst_out_valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ch0", 32'(bus.out_ch), 32'd0);
      check("post_rst_data", 32'(bus.out_data), 32'h11);

      // Random traffic checked by the scoreboard.
      do_reset();
      for (int k = 0; k < 300; k++) begin
         mode          = 1'($urandom_range(0, 1));
         sel           = SELW'($urandom_range(0, NCH - 1));
         bus.in_valid  = NCH'($urandom_range(0, (1 << NCH) - 1));
         bus.out_ready = 1'($urandom_range(0, 3) != 0);
         bus.in_data   = $urandom;
         tick();
      end
      bus.in_data = 32'h3CA5_5A11;

`ifdef MUX_STREAM_CNT_EN
      // 65537 back-to-back output transfers wrap the counter to 1.
      do_reset();
      mode = 1'b0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
      check("cnt_start", 32'(xfer_cnt), 32'd0);
      repeat (65536) tick();
      check("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
      repeat (2) tick();
      check("cnt_wrap", 32'(xfer_cnt), 32'd1);
`endif

      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
